// File: rtl/mips_pkg.sv
// Shared MIPS core constants: datapath width, register address width and
// the architecturally special register numbers.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_sb_read_port.sv
// One combinational register-file read port: zero-register check, write
// bypass (LMC over WB over array) and busy lookup for decode stall.
module rf_read_port
    import mips_pkg::*;
#(
    parameter int DW       = DATA_W,
    parameter int AW       = ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                nrst,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       regs [2**AW],
    input  logic [2**AW-1:0]    busy_vec,
    input  logic [2**AW-1:0]    wclr,
    input  logic                wr0_hit,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [DW-1:0]       wr0_data,
    input  logic                wr1_hit,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [DW-1:0]       wr1_data,
    output logic [DW-1:0]       data,
    output logic                busy
);

    // Later assignments take priority: LMC beats WB, zero register and
    // reset override everything.
    always_comb begin
        data = regs[addr];
        busy = busy_vec[addr] & ~wclr[addr];
        if (wr0_hit && wr0_addr == addr)
            data = wr0_data;
        if (wr1_hit && wr1_addr == addr)
            data = wr1_data;
        if (ZERO_REG != 0 && addr == AW'(REG_ZERO)) begin
            data = '0;
            busy = 1'b0;
        end
        if (!nrst) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port MIPS register file with WB and LMC write ports, built-in write
// bypass and a per-register busy scoreboard with a registered pending count.
module regfile_sb
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    wr0_en,
    input  logic [ADDR_W-1:0]       wr0_addr,
    input  logic [DATA_W-1:0]       wr0_data,
    input  logic                    wr1_en,
    input  logic [ADDR_W-1:0]       wr1_addr,
    input  logic [DATA_W-1:0]       wr1_data,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    input  logic                    flush,
    output logic [ADDR_W:0]         pend_cnt
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   next_busy;
    logic [NREG-1:0]   wclr;
    logic [NREG-1:0]   iset;
    logic [ADDR_W:0]   next_cnt;
    logic              wr0_hit;
    logic              wr1_hit;

    // A write to the hard-wired zero register is not a hit anywhere.
    assign wr0_hit = wr0_en && !(ZERO_REG != 0 && wr0_addr == ADDR_W'(REG_ZERO));
    assign wr1_hit = wr1_en && !(ZERO_REG != 0 && wr1_addr == ADDR_W'(REG_ZERO));

    // Issue re-arms a register even if it is being written or flushed this cycle.
    always_comb begin
        wclr      = '0;
        iset      = '0;
        next_busy = '0;
        next_cnt  = '0;
        for (int r = 0; r < NREG; r++) begin
            wclr[r]      = (wr0_hit && wr0_addr == ADDR_W'(r)) ||
                           (wr1_hit && wr1_addr == ADDR_W'(r));
            iset[r]      = iss_en && iss_addr == ADDR_W'(r) &&
                           !(ZERO_REG != 0 && r == REG_ZERO);
            next_busy[r] = (busy[r] & ~flush & ~wclr[r]) | iset[r];
            next_cnt     = next_cnt + (ADDR_W+1)'(next_busy[r]);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= next_busy;
            pend_cnt <= next_cnt;
        end
    end

    // WB first, LMC second, so LMC wins a same-address collision.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else begin
            if (wr0_hit)
                regs[wr0_addr] <= wr0_data;
            if (wr1_hit)
                regs[wr1_addr] <= wr1_data;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        rf_read_port #(
            .DW       (DATA_W),
            .AW       (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .nrst     (nrst),
            .addr     (rd_addr[g*ADDR_W +: ADDR_W]),
            .regs     (regs),
            .busy_vec (busy),
            .wclr     (wclr),
            .wr0_hit  (wr0_hit),
            .wr0_addr (wr0_addr),
            .wr0_data (wr0_data),
            .wr1_hit  (wr1_hit),
            .wr1_addr (wr1_addr),
            .wr1_data (wr1_data),
            .data     (rd_data[g*DATA_W +: DATA_W]),
            .busy     (rd_busy[g])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, randomized run
// against an array/bit-vector reference model, and an async reset corner.
module tb_regfile_sb;

    logic        clk;
    logic        nrst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en, wr1_en, iss_en, flush;
    logic [4:0]  wr0_addr, wr1_addr, iss_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [5:0]  pend_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eb0;
        logic        eb1;
        logic [5:0]  ep;
    } vec_t;

    vec_t tbl [$];

    // Reference model: plain storage plus one busy flag per register.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    regfile_sb dut (
        .clk      (clk),
        .nrst     (nrst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                                input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                                input logic ie, input logic [4:0] ia, input logic fl,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic eb0, input logic eb1, input logic [5:0] ep);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ie = ie; v.ia = ia; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
        v.e0 = e0; v.e1 = e1; v.eb0 = eb0; v.eb1 = eb1; v.ep = ep;
        return v;
    endfunction

    function automatic bit written(input logic [4:0] a);
        return a != 0 && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a));
    endfunction

    function automatic logic [31:0] model_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
        return m_mem[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a);
        return m_busy[a] && !written(a);
    endfunction

    function automatic int model_count();
        int n = 0;
        foreach (m_busy[r]) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic model_reset();
        foreach (m_mem[r]) begin
            m_mem[r]  = '0;
            m_busy[r] = 0;
        end
    endtask

    task automatic model_clock();
        bit nb [32];
        for (int r = 0; r < 32; r++)
            nb[r] = flush ? 0 : (m_busy[r] && !written(5'(r)));
        if (iss_en && iss_addr != 0) nb[iss_addr] = 1;
        if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
        m_busy = nb;
    endtask

    // One cycle: drive at negedge, check reads mid-cycle, check count after the edge.
    task automatic apply_stimulus(input vec_t v, input bit use_table);
        logic [31:0] e0, e1;
        logic        eb0, eb1;
        logic [5:0]  ep;
        @(negedge clk);
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        iss_en = v.ie;  iss_addr = v.ia;  flush = v.fl;
        rd_addr = {v.ra1, v.ra0};
        #1;
        if (use_table) begin
            e0 = v.e0; e1 = v.e1; eb0 = v.eb0; eb1 = v.eb1;
        end else begin
            e0 = model_data(v.ra0); e1 = model_data(v.ra1);
            eb0 = model_busy(v.ra0); eb1 = model_busy(v.ra1);
        end
        check_output("rd_data0", rd_data[31:0], e0);
        check_output("rd_data1", rd_data[63:32], e1);
        check_output("rd_busy0", 32'(rd_busy[0]), 32'(eb0));
        check_output("rd_busy1", 32'(rd_busy[1]), 32'(eb1));
        @(posedge clk);
        model_clock();
        #1;
        ep = use_table ? v.ep : 6'(model_count());
        check_output("pend_cnt", 32'(pend_cnt), 32'(ep));
    endtask

    task automatic idle_inputs();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        iss_en = 0; iss_addr = 0; flush = 0;
    endtask

    initial begin
        vec_t v;
        idle_inputs();
        rd_addr = '0;
        nrst = 1'b0;
        model_reset();
        #1;
        check_output("reset_pend", 32'(pend_cnt), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // Every register reads zero and idle after reset.
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            check_output("init_rd0", rd_data[31:0], 32'h0);
            check_output("init_rd1", rd_data[63:32], 32'h0);
            check_output("init_busy", 32'(rd_busy), 32'h0);
        end
        check_output("init_pend", 32'(pend_cnt), 32'h0);

        //              w0e w0a  w0d            w1e w1a w1d    ie ia fl ra0 ra1 e0            e1            eb0 eb1 ep
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  0, 0, 0, 0,  31, 32'h0,        32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 5,  32'hDEADBEEF,  0, 0,  32'h0,  0, 0, 0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  0, 0, 0, 5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 7,  32'h1,         1, 7,  32'h2,  0, 0, 0, 7,  7,  32'h2,        32'h2,        0, 0, 0));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  0, 0, 0, 7,  5,  32'h2,        32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  1, 9, 0, 9,  9,  32'h0,        32'h0,        0, 0, 1));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  0, 0, 0, 0,  9,  32'h0,        32'h0,        0, 1, 1));
        tbl.push_back(mk(0, 0,  32'h0,         1, 9,  32'h55, 0, 0, 0, 9,  9,  32'h55,       32'h55,       0, 0, 0));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  0, 0, 0, 9,  9,  32'h55,       32'h55,       0, 0, 0));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  1, 3, 0, 3,  3,  32'h0,        32'h0,        0, 0, 1));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  1, 4, 0, 3,  4,  32'h0,        32'h0,        1, 0, 2));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  1, 6, 0, 4,  6,  32'h0,        32'h0,        1, 0, 3));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  1, 8, 1, 3,  8,  32'h0,        32'h0,        1, 0, 1));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  0, 0, 0, 3,  8,  32'h0,        32'h0,        0, 1, 1));
        tbl.push_back(mk(1, 0,  32'hFFFFFFFF,  0, 0,  32'h0,  1, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0, 1));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  0, 0, 0, 0,  8,  32'h0,        32'h0,        0, 1, 1));
        tbl.push_back(mk(1, 8,  32'hA5,        0, 0,  32'h0,  1, 8, 0, 8,  8,  32'hA5,       32'hA5,       0, 0, 1));
        tbl.push_back(mk(0, 0,  32'h0,         0, 0,  32'h0,  0, 0, 0, 8,  4,  32'hA5,       32'h0,        1, 0, 1));
        tbl.push_back(mk(0, 0,  32'h0,         1, 0,  32'h77, 0, 0, 1, 0,  8,  32'h0,        32'hA5,       0, 1, 0));

        foreach (tbl[i]) apply_stimulus(tbl[i], 1'b1);

        // Randomized traffic on a narrow address range to force collisions.
        for (int n = 0; n < 400; n++) begin
            v = mk($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                   $urandom_range(0, 19) == 0,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                   '0, '0, 0, 0, '0);
            apply_stimulus(v, 1'b0);
        end

        // Three registers pending, then reset asserted mid-cycle.
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 1), 1'b1);
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 2), 1'b1);
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 1, 12, 0, 10, 11, 0, 0, 1, 1, 3), 1'b1);
        @(negedge clk);
        wr0_en = 1; wr0_addr = 5'd13; wr0_data = 32'h1234;
        iss_en = 1; iss_addr = 5'd14;
        rd_addr = {5'd10, 5'd13};
        #2;
        nrst = 1'b0;
        #1;
        check_output("rst_pend", 32'(pend_cnt), 32'h0);
        check_output("rst_rd0", rd_data[31:0], 32'h0);
        check_output("rst_busy", 32'(rd_busy), 32'h0);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 14, 5, 0, 0, 0, 0, 0), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
